// File: rtl/chroma_sub422_pkg.sv
// rtl/chroma_sub422_pkg.sv - shared packing constants, phase encoding and counter sizing
package chroma_sub422_pkg;

    localparam int CHROMA_MSB = 15;
    localparam int CHROMA_LSB = 8;
    localparam int LUMA_MSB   = 7;
    localparam int LUMA_LSB   = 0;

    typedef enum logic {
        PH_EVEN = 1'b0,
        PH_ODD  = 1'b1
    } phase_t;

    // Smallest width whose range covers every pixel index of a line.
    function automatic int calc_cnt_w(input int line_w);
        int w;
        w = 1;
        while ((1 << w) < line_w) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic logic [15:0] pack_word(input logic [7:0] chroma, input logic [7:0] luma);
        logic [15:0] word;
        word = '0;
        word[CHROMA_MSB:CHROMA_LSB] = chroma;
        word[LUMA_MSB:LUMA_LSB]     = luma;
        return word;
    endfunction

endpackage

// File: rtl/chroma_sub422_if.sv
// rtl/chroma_sub422_if.sv - pixel input / packed 4:2:2 output bundle
interface chroma_sub422_if;
    logic [7:0]  din_y;
    logic [7:0]  din_cb;
    logic [7:0]  din_cr;
    logic        din_vld;
    logic        din_sof;
    logic [15:0] dout;
    logic        dout_vld;
    logic        dout_sof;
    logic        dout_eol;
    logic        err_align;

    modport master (
        output din_y, din_cb, din_cr, din_vld, din_sof,
        input  dout, dout_vld, dout_sof, dout_eol, err_align
    );

    modport slave (
        input  din_y, din_cb, din_cr, din_vld, din_sof,
        output dout, dout_vld, dout_sof, dout_eol, err_align
    );
endinterface

// File: rtl/chroma_sub422_avg2.sv
// rtl/chroma_sub422_avg2.sv - combinational two-input 8-bit average, rounding selectable
module chroma_avg2 #(
    parameter int ROUND = 1
) (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] avg
);
    logic [8:0] sum;

    // 9-bit sum holds 255+255+1, so the halved result always fits in 8 bits.
    assign sum = {1'b0, a} + {1'b0, b} + ((ROUND != 0) ? 9'd1 : 9'd0);
    assign avg = 8'(sum >> 1);

endmodule

// File: rtl/chroma_sub422.sv
// rtl/chroma_sub422.sv - streaming 4:4:4 to 4:2:2 horizontal chroma subsampler
module chroma_sub422
    import chroma_sub422_pkg::*;
#(
    parameter int LINE_W = 1280,
    parameter int CNT_W  = calc_cnt_w(LINE_W),
    parameter int ROUND  = 1
) (
    input  logic           clk,
    input  logic           rstn,
    chroma_sub422_if.slave px
);

    if (LINE_W < 2 || (LINE_W % 2) != 0) begin : g_bad_line_w
        $error("chroma_sub422: LINE_W must be even and >= 2");
    end
    if ((64'd1 << CNT_W) < 64'(LINE_W)) begin : g_bad_cnt_w
        $error("chroma_sub422: CNT_W too narrow for LINE_W");
    end

    phase_t           phase, phase_nx;
    logic [CNT_W-1:0] pix_cnt, idx;
    logic             last, take_even, take_odd, resync;
    logic [7:0]       y0, cb0, cr0;
    logic             sof0;
    logic [7:0]       cb_avg, cr_avg;
    logic [15:0]      out_word, b_word;
    logic             out_vld, out_sof, out_eol, b_pend, b_eol, err;

    chroma_avg2 #(.ROUND(ROUND)) u_avg_cb (.a(cb0), .b(px.din_cb), .avg(cb_avg));
    chroma_avg2 #(.ROUND(ROUND)) u_avg_cr (.a(cr0), .b(px.din_cr), .avg(cr_avg));

    assign idx  = px.din_sof ? '0 : pix_cnt;
    assign last = (idx == CNT_W'(LINE_W - 1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase <= PH_EVEN;
        end else begin
            phase <= phase_nx;
        end
    end

    // A sof pixel always opens a pair; in ODD it also discards the held pixel.
    always_comb begin
        phase_nx  = phase;
        take_even = 1'b0;
        take_odd  = 1'b0;
        resync    = 1'b0;
        if (px.din_vld) begin
            case (phase)
                PH_EVEN: begin
                    take_even = 1'b1;
                    phase_nx  = PH_ODD;
                end
                PH_ODD: begin
                    if (px.din_sof) begin
                        take_even = 1'b1;
                        resync    = 1'b1;
                        phase_nx  = PH_ODD;
                    end else begin
                        take_odd = 1'b1;
                        phase_nx = PH_EVEN;
                    end
                end
                default: phase_nx = PH_EVEN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pix_cnt  <= '0;
            y0       <= '0;
            cb0      <= '0;
            cr0      <= '0;
            sof0     <= 1'b0;
            err      <= 1'b0;
            out_word <= '0;
            out_vld  <= 1'b0;
            out_sof  <= 1'b0;
            out_eol  <= 1'b0;
            b_word   <= '0;
            b_pend   <= 1'b0;
            b_eol    <= 1'b0;
        end else begin
            if (px.din_vld) begin
                pix_cnt <= last ? '0 : idx + 1'b1;
            end
            if (take_even) begin
                y0   <= px.din_y;
                cb0  <= px.din_cb;
                cr0  <= px.din_cr;
                sof0 <= px.din_sof;
            end
            if (resync) begin
                err <= 1'b1;
            end
            // Word B waits one cycle in its own register so the next even pixel never collides.
            if (take_odd) begin
                out_word <= pack_word(cb_avg, y0);
                out_vld  <= 1'b1;
                out_sof  <= sof0;
                out_eol  <= 1'b0;
                b_word   <= pack_word(cr_avg, px.din_y);
                b_pend   <= 1'b1;
                b_eol    <= last;
            end else if (b_pend) begin
                out_word <= b_word;
                out_vld  <= 1'b1;
                out_sof  <= 1'b0;
                out_eol  <= b_eol;
                b_pend   <= 1'b0;
            end else begin
                out_word <= '0;
                out_vld  <= 1'b0;
                out_sof  <= 1'b0;
                out_eol  <= 1'b0;
            end
        end
    end

    assign px.dout      = out_word;
    assign px.dout_vld  = out_vld;
    assign px.dout_sof  = out_sof;
    assign px.dout_eol  = out_eol;
    assign px.err_align = err;

endmodule

// File: tb/tb_chroma_sub422.sv
// tb/tb_chroma_sub422.sv - scoreboard bench for chroma_sub422, rounding and truncating instances
module tb_chroma_sub422;

    typedef struct {
        logic [15:0] data;
        logic        sof;
        logic        eol;
        int          cyc;
    } exp_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   n_checks;
    int   n_fail;
    exp_t q1[$];
    exp_t q0[$];

    chroma_sub422_if if_r1 ();
    chroma_sub422_if if_r0 ();

    chroma_sub422 #(.LINE_W(4), .ROUND(1)) dut_r1 (.clk(clk), .rstn(rstn), .px(if_r1));
    chroma_sub422 #(.LINE_W(4), .ROUND(0)) dut_r0 (.clk(clk), .rstn(rstn), .px(if_r0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        n_checks++;
        if (if_r1.dout_vld === 1'b1) begin
            if (q1.size() == 0) begin
                n_fail++;
                $display("FAIL r1_unexpected_word cyc=%0d got dout=%h sof=%b eol=%b, required no output", cyc, if_r1.dout, if_r1.dout_sof, if_r1.dout_eol);
            end else begin
                e = q1.pop_front();
                if ({if_r1.dout, if_r1.dout_sof, if_r1.dout_eol} !== {e.data, e.sof, e.eol} || cyc != e.cyc)
                begin
                    n_fail++;
                    $display("FAIL r1_word got dout=%h sof=%b eol=%b cyc=%0d, required dout=%h sof=%b eol=%b cyc=%0d", if_r1.dout, if_r1.dout_sof, if_r1.dout_eol, cyc, e.data, e.sof, e.eol, e.cyc);
                end
            end
        end else if ({if_r1.dout_vld, if_r1.dout, if_r1.dout_sof, if_r1.dout_eol} !== 19'd0) begin
            n_fail++;
            $display("FAIL r1_idle_outputs cyc=%0d got vld=%b dout=%h sof=%b eol=%b, required all 0", cyc, if_r1.dout_vld, if_r1.dout, if_r1.dout_sof, if_r1.dout_eol);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        n_checks++;
        if (if_r0.dout_vld === 1'b1) begin
            if (q0.size() == 0) begin
                n_fail++;
                $display("FAIL r0_unexpected_word cyc=%0d got dout=%h sof=%b eol=%b, required no output", cyc, if_r0.dout, if_r0.dout_sof, if_r0.dout_eol);
            end else begin
                e = q0.pop_front();
                if ({if_r0.dout, if_r0.dout_sof, if_r0.dout_eol} !== {e.data, e.sof, e.eol} || cyc != e.cyc)
                begin
                    n_fail++;
                    $display("FAIL r0_word got dout=%h sof=%b eol=%b cyc=%0d, required dout=%h sof=%b eol=%b cyc=%0d", if_r0.dout, if_r0.dout_sof, if_r0.dout_eol, cyc, e.data, e.sof, e.eol, e.cyc);
                end
            end
        end else if ({if_r0.dout_vld, if_r0.dout, if_r0.dout_sof, if_r0.dout_eol} !== 19'd0) begin
            n_fail++;
            $display("FAIL r0_idle_outputs cyc=%0d got vld=%b dout=%h sof=%b eol=%b, required all 0", cyc, if_r0.dout_vld, if_r0.dout, if_r0.dout_sof, if_r0.dout_eol);
        end
    end

    function automatic logic [7:0] avg(input int a, input int b, input int r);
        return 8'((a + b + r) / 2);
    endfunction

    // Drives one cycle on both instances; acc is the cycle count at which the edge sampling it completes.
    task automatic drive(input bit v, input int y, input int cb, input int cr, input bit sof, output int acc);
        @(posedge clk);
        #1;
        if_r1.din_vld = v;  if_r1.din_y = 8'(y); if_r1.din_cb = 8'(cb); if_r1.din_cr = 8'(cr); if_r1.din_sof = sof;
        if_r0.din_vld = v;  if_r0.din_y = 8'(y); if_r0.din_cb = 8'(cb); if_r0.din_cr = 8'(cr); if_r0.din_sof = sof;
        acc = cyc + 1;
    endtask

    task automatic push_exp(input int acc, input logic [15:0] a1, input logic [15:0] b1,
                            input logic [15:0] a0, input logic [15:0] b0, input bit sof, input bit eol);
        q1.push_back('{a1, sof, 1'b0, acc});
        q1.push_back('{b1, 1'b0, eol, acc + 1});
        q0.push_back('{a0, sof, 1'b0, acc});
        q0.push_back('{b0, 1'b0, eol, acc + 1});
    endtask

    task automatic push_pair(input int acc, input int y0, input int cb0, input int cr0,
                             input int y1, input int cb1, input int cr1, input bit sof, input bit eol);
        push_exp(acc, {avg(cb0, cb1, 1), 8'(y0)}, {avg(cr0, cr1, 1), 8'(y1)},
                      {avg(cb0, cb1, 0), 8'(y0)}, {avg(cr0, cr1, 0), 8'(y1)}, sof, eol);
    endtask

    task automatic flush();
        int acc;
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 0, acc);
        @(posedge clk);
        #1;
        n_checks++;
        if (q1.size() != 0 || q0.size() != 0) begin
            n_fail++;
            $display("FAIL flush_queues got pending r1=%0d r0=%0d, required 0", q1.size(), q0.size());
            q1.delete();
            q0.delete();
        end
    endtask

    task automatic test_reset();
        int acc;
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, acc);
        drive(0, 0, 0, 0, 0, acc);
        n_checks++;
        if ({if_r1.dout, if_r1.dout_vld, if_r1.dout_sof, if_r1.dout_eol, if_r1.err_align,
             if_r0.dout, if_r0.dout_vld, if_r0.dout_sof, if_r0.dout_eol, if_r0.err_align} !== 40'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got r1 dout=%h err=%b r0 dout=%h err=%b, required all 0", if_r1.dout, if_r1.err_align, if_r0.dout, if_r0.err_align);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic test_basic_pair();
        int acc;
        drive(1, 10, 100, 200, 1, acc);
        drive(1, 20, 101, 201, 0, acc);
        push_exp(acc, 16'h650A, 16'hC914, 16'h640A, 16'hC814, 1'b1, 1'b0);
        flush();
    endtask

    task automatic test_continuous();
        int acc;
        int py, pcb, pcr;
        for (int i = 0; i < 8; i++) begin
            drive(1, i * 3 + 1, i * 17, 255 - i * 9, i == 0, acc);
            if (i % 2 == 1) push_pair(acc, py, pcb, pcr, i * 3 + 1, i * 17, 255 - i * 9, i == 1, i == 3 || i == 7);
            py = i * 3 + 1; pcb = i * 17; pcr = 255 - i * 9;
        end
        flush();
    endtask

    task automatic test_gap();
        int acc;
        drive(1, 30, 40, 60, 0, acc);
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, acc);
        drive(1, 31, 43, 61, 0, acc);
        push_pair(acc, 30, 40, 60, 31, 43, 61, 1'b0, 1'b0);
        flush();
    endtask

    task automatic test_extremes();
        int acc;
        drive(1, 1, 255, 0, 0, acc);
        drive(1, 2, 255, 1, 0, acc);
        push_exp(acc, 16'hFF01, 16'h0102, 16'hFF01, 16'h0002, 1'b0, 1'b1);
        drive(1, 3, 0, 255, 0, acc);
        drive(1, 4, 1, 255, 0, acc);
        push_exp(acc, 16'h0103, 16'hFF04, 16'h0003, 16'hFF04, 1'b0, 1'b0);
        flush();
    endtask

    task automatic test_misaligned_sof();
        int acc;
        drive(1, 5, 10, 20, 1, acc);
        drive(1, 6, 12, 22, 0, acc);
        push_pair(acc, 5, 10, 20, 6, 12, 22, 1'b1, 1'b0);
        drive(1, 8, 30, 30, 0, acc);
        n_checks++;
        if (if_r1.err_align !== 1'b0 || if_r0.err_align !== 1'b0) begin
            n_fail++;
            $display("FAIL err_align_before got r1=%b r0=%b, required 0", if_r1.err_align, if_r0.err_align);
        end
        drive(1, 7, 50, 50, 1, acc);
        drive(1, 9, 52, 52, 0, acc);
        push_exp(acc, 16'h3307, 16'h3309, 16'h3307, 16'h3309, 1'b1, 1'b0);
        flush();
        n_checks++;
        if (if_r1.err_align !== 1'b1 || if_r0.err_align !== 1'b1) begin
            n_fail++;
            $display("FAIL err_align_sticky got r1=%b r0=%b, required 1", if_r1.err_align, if_r0.err_align);
        end
    endtask

    task automatic test_reset_midpair();
        int acc;
        drive(1, 90, 91, 92, 1, acc);
        drive(0, 0, 0, 0, 0, acc);
        rstn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if ({if_r1.dout, if_r1.dout_vld, if_r1.dout_sof, if_r1.dout_eol, if_r1.err_align,
                 if_r0.dout, if_r0.dout_vld, if_r0.dout_sof, if_r0.dout_eol, if_r0.err_align} !== 40'd0) begin
                n_fail++;
                $display("FAIL midpair_reset_outputs got r1 vld=%b err=%b r0 vld=%b err=%b, required all 0", if_r1.dout_vld, if_r1.err_align, if_r0.dout_vld, if_r0.err_align);
            end
            drive(0, 0, 0, 0, 0, acc);
        end
        rstn = 1'b1;
        drive(1, 11, 20, 30, 0, acc);
        drive(1, 12, 21, 31, 0, acc);
        push_pair(acc, 11, 20, 30, 12, 21, 31, 1'b0, 1'b0);
        drive(1, 13, 22, 32, 0, acc);
        drive(1, 14, 23, 33, 0, acc);
        push_pair(acc, 13, 22, 32, 14, 23, 33, 1'b0, 1'b1);
        flush();
    endtask

    initial begin
        int acc;
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        if_r1.din_vld = 1'b0; if_r1.din_sof = 1'b0; if_r1.din_y = '0; if_r1.din_cb = '0; if_r1.din_cr = '0;
        if_r0.din_vld = 1'b0; if_r0.din_sof = 1'b0; if_r0.din_y = '0; if_r0.din_cb = '0; if_r0.din_cr = '0;
        test_reset();
        test_basic_pair();
        test_continuous();
        test_gap();
        test_extremes();
        test_misaligned_sof();
        test_reset_midpair();
        drive(0, 0, 0, 0, 0, acc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d, required completion", cyc);
        $fatal(1);
    end

endmodule

// File: doc/chroma_sub422.md
Name: chroma_sub422

Overview:
- Streaming 4:4:4 to 4:2:2 horizontal chroma subsampler.
- Sits directly downstream of the per-pixel RGB to YCbCr conversion stages. It takes one Y/Cb/Cr triple per din_vld and emits one 16-bit packed 4:2:2 word per input pixel.
- Each horizontal pair of pixels (even, odd) shares one averaged Cb and one averaged Cr.
- No backpressure: throughput is 1 pixel in / 1 word out per cycle. Latency is fixed.

Parameters:
- LINE_W, 1280: active pixels per line. Must be even and >= 2; elaboration fails otherwise.
- CNT_W, 11: pixel counter width. Must satisfy 2^CNT_W >= LINE_W.
- ROUND, 1: chroma averaging mode. 1 = round half up, (a+b+1)>>1. 0 = truncate, (a+b)>>1.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous reset, active-low.
- din_y  in  8  luma, unsigned.
- din_cb  in  8  Cb, unsigned, offset 128.
- din_cr  in  8  Cr, unsigned, offset 128.
- din_vld  in  1  input pixel valid.
- din_sof  in  1  first pixel of frame; qualified by din_vld.
- dout  out  16  packed word. Even slot = {Cb_avg, Y_even}; odd slot = {Cr_avg, Y_odd}. Chroma is always in [15:8].
- dout_vld  out  1  output word valid.
- dout_sof  out  1  high with the first word of a frame.
- dout_eol  out  1  high with the last word of each line.
- err_align  out  1  sticky flag: frame start arrived mid-pair.

Behaviour:
- Reset: all outputs 0; pix_cnt=0; phase=EVEN; all holding registers 0. Reset mid-line drops any partial pair with no output.
- Consumption: din_* are sampled only when din_vld=1. Idle cycles may occur anywhere, including between the two pixels of a pair; held state is retained across them.
- pix_cnt increments on each valid pixel and wraps LINE_W-1 -> 0. When din_sof=1 with din_vld, that pixel is index 0 regardless of pix_cnt.
- Phase FSM, two states:
  - EVEN: a valid pixel latches y0/cb0/cr0/sof0, then -> ODD.
  - ODD: a valid pixel (y1, cb1, cr1) computes cb_avg=avg(cb0,cb1) and cr_avg=avg(cr0,cr1) with 9-bit intermediate sums; the result never exceeds 255. It loads output word A={cb_avg,y0} and holding word B={cr_avg,y1}, then -> EVEN.
- Output timing: if pixel 1 of a pair is accepted at cycle t:
  - cycle t+1: dout=A, dout_vld=1, dout_sof=sof0.
  - cycle t+2: dout=B, dout_vld=1, dout_eol=1 iff pixel 1 had index LINE_W-1.
- B is held in its own register, so a new even pixel arriving at t+1 causes no conflict. Back-to-back pairs give a continuous dout_vld.
- When dout_vld=0: dout=0, dout_sof=0, dout_eol=0.
- din_sof while phase=ODD:
  - held pixel 0 is discarded, with no output for it;
  - err_align is set, sticky until rstn;
  - the sof pixel becomes pixel 0 of a new pair (phase -> ODD, pix_cnt restarts at index 0).
- din_sof while phase=EVEN: normal; err_align unchanged.
- A line shorter than LINE_W followed by din_sof is handled by the resync rule above. No dout_eol is issued for the short line.

Decomposition:
- Shared package holds:
  - packing constants: chroma field [15:8], luma field [7:0];
  - phase encoding: EVEN=1'b0, ODD=1'b1;
  - a function computing CNT_W from LINE_W, so users can leave CNT_W at its derived value.
- One natural sub-module: chroma_avg2, a combinational 8-bit two-input average with the ROUND parameter. It is instantiated twice (Cb, Cr).

Test Plan:
- Basic pair: sof pixel (Y=10,Cb=100,Cr=200) then (Y=20,Cb=101,Cr=201), back to back.
  - ROUND=1 -> dout=0x650A with dout_sof=1, then 0xC914.
  - ROUND=0 -> 0x640A, then 0xC814.
- Continuous stream, LINE_W=4, 8 pixels.
  - dout_vld high for 8 consecutive cycles starting 2 cycles after the first pixel.
  - dout_eol on words 4 and 8 only.
  - dout_sof on word 1 only.
- Gapped input, LINE_W=4: pixel 0, three idle cycles, pixel 1.
  - Word A appears exactly 1 cycle after pixel 1; values are correct.
  - No output during the gap.
- Misaligned sof, LINE_W=4: three pixels, then sof pixel (Cb=Cr=50, Y=7), then pixel (Cb=Cr=52, Y=9).
  - Word from pixel 3 is dropped; err_align=1 from then on.
  - Next words are 0x3307 with dout_sof=1, then 0x3309.
- Extremes: Cb pair 255/255 -> 0xFF; pair 0/1 -> 0x01 (ROUND=1) or 0x00 (ROUND=0). No overflow.
- Reset: assert rstn low between pixel 0 and pixel 1, then release.
  - All outputs 0 during reset.
  - The next pixel is treated as EVEN index 0; no output is produced from pre-reset data.
